// File: rtl/dmem_arbiter_if.sv
// Shared bus bundle between core, DMA master, data memory and dmem_arbiter.
// The arbiter takes the slave side; requesters and memory take the master side.
interface dmem_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [2:0]  c_funct3;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        d_req;
    logic        d_lock;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [31:0] m_addr;
    logic [31:0] m_dataW;
    logic        m_MemRW;
    logic [2:0]  m_funct3;
    logic [31:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_funct3,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_lock, d_we, d_addr, d_wdata, d_funct3,
        output d_gnt, d_rvalid, d_rdata,
        output m_addr, m_dataW, m_MemRW, m_funct3,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_funct3,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_lock, d_we, d_addr, d_wdata, d_funct3,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_addr, m_dataW, m_MemRW, m_funct3,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for the single-ported data memory, with bounded DMA lock.
// Define DMEM_ARB_RR_EN for round-robin contention; default is core priority.
module dmem_arbiter #(
    parameter int LOCK_MAX = 16,
    parameter int CNT_W    = 8
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    typedef enum logic {IDLE, DLOCK} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             lock_hit;
    logic             c_gnt, d_gnt;

`ifdef DMEM_ARB_RR_EN
    // 1 = DMA was granted last, so the core wins the next contention
    logic rr_last, rr_last_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        cnt_inc   = cnt + CNT_W'(1);
        lock_hit  = (cnt_inc >= CNT_W'(LOCK_MAX));
`ifdef DMEM_ARB_RR_EN
        rr_last_nxt = rr_last;
`endif
        unique case (state)
            IDLE: begin
                case ({bus.c_req, bus.d_req})
                    2'b11: begin
`ifdef DMEM_ARB_RR_EN
                        c_gnt = rr_last;
                        d_gnt = ~rr_last;
`else
                        c_gnt = 1'b1;
`endif
                    end
                    2'b10:   c_gnt = 1'b1;
                    2'b01:   d_gnt = 1'b1;
                    default: ;
                endcase
                // A lock of one beat is just an ordinary grant
                if (d_gnt && bus.d_lock && (LOCK_MAX > 1)) begin
                    state_nxt = DLOCK;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            DLOCK: begin
                d_gnt = bus.d_req;
                if (bus.d_req) begin
                    if (!bus.d_lock || lock_hit) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else if (!bus.d_lock) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
`ifdef DMEM_ARB_RR_EN
        if (c_gnt)
            rr_last_nxt = 1'b0;
        else if (d_gnt)
            rr_last_nxt = 1'b1;
        if (state == DLOCK && state_nxt == IDLE)
            rr_last_nxt = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.c_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.c_rdata  <= '0;
            bus.d_rdata  <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_last      <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bus.c_rvalid <= c_gnt & ~bus.c_we;
            bus.d_rvalid <= d_gnt & ~bus.d_we;
            if (c_gnt && !bus.c_we)
                bus.c_rdata <= bus.m_rdata;
            if (d_gnt && !bus.d_we)
                bus.d_rdata <= bus.m_rdata;
`ifdef DMEM_ARB_RR_EN
            rr_last      <= rr_last_nxt;
`endif
        end
    end

    assign bus.c_gnt    = c_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.m_addr   = d_gnt ? bus.d_addr : bus.c_addr;
    assign bus.m_dataW  = d_gnt ? bus.d_wdata : bus.c_wdata;
    assign bus.m_funct3 = d_gnt ? bus.d_funct3 : bus.c_funct3;
    assign bus.m_MemRW  = (c_gnt & bus.c_we) | (d_gnt & bus.d_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles queue expected grants
// and read returns; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

    localparam int LOCK_MAX = 4;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [1:0] GC = 2'b10;
    localparam logic [1:0] GD = 2'b01;
    localparam logic [1:0] GN = 2'b00;

    typedef struct {
        int          cyc;
        logic [31:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    exp_t gq[$];
    exp_t cq[$];
    exp_t dq[$];

    dmem_arbiter_if bus ();

    dmem_arbiter #(.LOCK_MAX(LOCK_MAX), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.m_rdata = mem[bus.m_addr[7:2]];
    always @(posedge clk)
        if (bus.m_MemRW) mem[bus.m_addr[7:2]] <= bus.m_dataW;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endfunction

    task automatic step(input logic r, input logic cr, input logic cw,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dl, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd,
                        input logic [1:0] eg);
        logic we_exp;
        @(posedge clk);
        #1;
        run          = 1'b1;
        rst          = r;
        bus.c_req    = cr;
        bus.c_we     = cw;
        bus.c_addr   = ca;
        bus.c_wdata  = cd;
        bus.d_req    = dr;
        bus.d_lock   = dl;
        bus.d_we     = dw;
        bus.d_addr   = da;
        bus.d_wdata  = dd;
        we_exp = (eg[1] & cw) | (eg[0] & dw);
        gq.push_back('{cyc, {29'b0, we_exp, eg}});
        if (eg[1] && cw) ref_mem[ca[7:2]] = cd;
        if (eg[0] && dw) ref_mem[da[7:2]] = dd;
        if (eg[1] && !cw && !r) cq.push_back('{cyc + 1, ref_mem[ca[7:2]]});
        if (eg[0] && !dw && !r) dq.push_back('{cyc + 1, ref_mem[da[7:2]]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, GN);
    endtask

    always @(negedge clk) begin
        if (run) begin
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                chk("gnt_we", {29'b0, bus.m_MemRW, bus.c_gnt, bus.d_gnt}, gq[0].v);
                void'(gq.pop_front());
            end
            while (cq.size() > 0 && cq[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL c_stale cyc=%0d actual=none required=%h", cyc, cq[0].v);
                void'(cq.pop_front());
            end
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL d_stale cyc=%0d actual=none required=%h", cyc, dq[0].v);
                void'(dq.pop_front());
            end
            if (cq.size() > 0 && cq[0].cyc == cyc) begin
                chk("c_rvalid", {31'b0, bus.c_rvalid}, 1);
                chk("c_rdata", bus.c_rdata, cq[0].v);
                void'(cq.pop_front());
            end else begin
                chk("c_rvalid", {31'b0, bus.c_rvalid}, 0);
            end
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                chk("d_rvalid", {31'b0, bus.d_rvalid}, 1);
                chk("d_rdata", bus.d_rdata, dq[0].v);
                void'(dq.pop_front());
            end else begin
                chk("d_rvalid", {31'b0, bus.d_rvalid}, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.c_funct3 = 3'b010; bus.d_funct3 = 3'b010;
        bus.d_req = 0; bus.d_lock = 0; bus.d_we = 0; bus.d_addr = 0;
        bus.d_wdata = 0;

        // reset with both requesting; first post-reset cycle shows the policy
        step(1'b1, 1, 0, 32'h00, 0, 1, 0, 0, 32'h04, 0, RR ? GD : GC);
        step(1'b1, 1, 0, 32'h00, 0, 1, 0, 0, 32'h04, 0, RR ? GD : GC);
        step(1'b0, 1, 0, 32'h00, 0, 1, 0, 0, 32'h04, 0, RR ? GD : GC);
        chk("c_rdata_rst", bus.c_rdata, 0);
        chk("d_rdata_rst", bus.d_rdata, 0);

        // core write then read back
        step(1'b0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, GC);
        step(1'b0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, GC);

        // contention for four cycles
        step(1'b0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, RR ? GD : GC);
        step(1'b0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, GC);
        step(1'b0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, RR ? GD : GC);
        step(1'b0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, GC);

        // lock runs to LOCK_MAX beats, then the core gets in
        step(1'b0, 0, 0, 32'h10, 0, 1, 1, 1, 32'h40, 32'hA000_0040, GD);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 1, 32'h44, 32'hA000_0044, GD);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 1, 32'h48, 32'hA000_0048, GD);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 1, 32'h4C, 32'hA000_004C, GD);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h44, 0, GC);
        step(1'b0, 0, 0, 32'h10, 0, 1, 0, 0, 32'h44, 0, GD);

        // early release after three beats
        step(1'b0, 0, 0, 32'h10, 0, 1, 1, 0, 32'h40, 0, GD);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h48, 0, GD);
        step(1'b0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h4C, 0, GD);
        step(1'b0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h4C, 0, GC);

        // reset in the middle of a lock
        step(1'b0, 0, 0, 32'h10, 0, 1, 1, 0, 32'h48, 0, GD);
        step(1'b0, 0, 0, 32'h10, 0, 1, 1, 0, 32'h48, 0, GD);
        step(1'b1, 1, 0, 32'h10, 0, 1, 1, 0, 32'h4C, 0, GD);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h40, 0, RR ? GD : GC);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h40, 0, RR ? GD : GC);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h40, 0, RR ? GD : GC);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h40, 0, RR ? GD : GC);
        step(1'b0, 1, 0, 32'h10, 0, 1, 1, 0, 32'h40, 0, GC);

        idle(3);
        @(posedge clk);
        #1;
        chk("gq_left", gq.size(), 0);
        chk("cq_left", cq.size(), 0);
        chk("dq_left", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
